// File: rtl/fifo_n_pkg.sv
// Shared helpers for the fifo_n block: elaboration-time parameter range checks.
package fifo_n_pkg;

  function automatic bit lvl_ok(input int lvl, input int lo, input int hi);
    return (lvl >= lo) && (lvl <= hi);
  endfunction

endpackage

// File: rtl/fifo_n_if.sv
// Handshake, data and status bundle between a producer/consumer (master) and fifo_n (slave).
interface fifo_n_if #(
  parameter int DW = 16,
  parameter int AW = 2
);
  logic          flush;
  logic          wr;
  logic [DW-1:0] din;
  logic          rd;
  logic [DW-1:0] dout;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          af;
  logic          ae;
  logic          ovf;
  logic          udf;

  modport master (
    output flush, wr, din, rd,
    input  dout, wa, ra, count, full, empty, af, ae, ovf, udf
  );

  modport slave (
    input  flush, wr, din, rd,
    output dout, wa, ra, count, full, empty, af, ae, ovf, udf
  );
endinterface

// File: rtl/fifo_n_ram.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port (distributed RAM).
module fifo_ram #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_n.sv
// Show-ahead synchronous FIFO: AW+1 bit pointers, fill count, threshold flags and sticky errors.
module fifo_n
  import fifo_n_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 2,
  parameter int AF_LVL = 2**AW - 1,
  parameter int AE_LVL = 1
) (
  input  logic     clk,
  input  logic     rst,
  fifo_n_if.slave  bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

  if (!lvl_ok(AF_LVL, 1, DEPTH)) begin : g_bad_af
    $fatal(1, "fifo_n: AF_LVL out of range 1..DEPTH");
  end
  if (!lvl_ok(AE_LVL, 0, DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "fifo_n: AE_LVL out of range 0..DEPTH-1");
  end

  logic [AW:0] wp, rp, cnt;
  logic        ovf_q, udf_q;
  logic        full, empty, wr_ok, rd_ok;

  assign cnt   = wp - rp;
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);

  // Memory write is also blocked during reset/flush so ignored writes leave no trace.
  assign wr_ok = bus.wr & ~full & rst & ~bus.flush;
  assign rd_ok = bus.rd & ~empty;

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      if (bus.wr && full)  ovf_q <= 1'b1;
      if (bus.rd && empty) udf_q <= 1'b1;
    end
  end

  fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp[AW-1:0]),
    .wdata (bus.din),
    .raddr (rp[AW-1:0]),
    .rdata (bus.dout)
  );

  assign bus.wa    = wp[AW-1:0];
  assign bus.ra    = rp[AW-1:0];
  assign bus.count = cnt;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.af    = (cnt >= AF_C);
  assign bus.ae    = (cnt <= AE_C);
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
endmodule

// File: tb/tb_fifo_n.sv
// Directed vector table on a 4x8 FIFO plus a randomized reference-queue run on a 16x16 FIFO.
module tb_fifo_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_n_if #(.DW(8),  .AW(2)) sbus ();
  fifo_n_if #(.DW(16), .AW(4)) bbus ();

  fifo_n #(.DW(8), .AW(2), .AF_LVL(3), .AE_LVL(1)) u_small (
    .clk (clk), .rst (rst), .bus (sbus.slave)
  );
  fifo_n #(.DW(16), .AW(4), .AF_LVL(12), .AE_LVL(1)) u_big (
    .clk (clk), .rst (rst), .bus (bbus.slave)
  );

  typedef struct {
    bit         r_n;
    bit         flush;
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         count;
    int         wa;
    int         ra;
    bit         ovf;
    bit         udf;
    bit         chkd;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit r_n, bit f, bit w, bit r, logic [7:0] d, int c,
                              int wa, int ra, bit o, bit u, bit chkd, logic [7:0] dx);
    vec_t v;
    v.r_n = r_n; v.flush = f; v.wr = w; v.rd = r; v.din = d;
    v.count = c; v.wa = wa; v.ra = ra; v.ovf = o; v.udf = u;
    v.chkd = chkd; v.dout = dx;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  // Random-phase reference model for the deep instance.
  logic [15:0] q[$];
  bit          m_ovf, m_udf;

  initial begin
    // Reset with wr=rd=1 held
    tbl.push_back(mk(0,0,1,1,8'hAA, 0,0,0,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,1,1,8'hAA, 0,0,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,0,0,8'h00, 0,0,0,0,0, 0,8'h00));
    // Fill, overflow, drain, underflow
    tbl.push_back(mk(1,0,1,0,8'h11, 1,1,0,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,1,0,8'h22, 2,2,0,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,1,0,8'h33, 3,3,0,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,1,0,8'h44, 4,0,0,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,1,0,8'h55, 4,0,0,1,0, 1,8'h11));
    tbl.push_back(mk(1,0,0,1,8'h00, 3,0,1,1,0, 1,8'h22));
    tbl.push_back(mk(1,0,0,1,8'h00, 2,0,2,1,0, 1,8'h33));
    tbl.push_back(mk(1,0,0,1,8'h00, 1,0,3,1,0, 1,8'h44));
    tbl.push_back(mk(1,0,0,1,8'h00, 0,0,0,1,0, 0,8'h00));
    tbl.push_back(mk(1,0,0,1,8'h00, 0,0,0,1,1, 0,8'h00));
    // Flush with wr=1 clears errors and ignores the write; then preload two words
    tbl.push_back(mk(1,1,1,0,8'h99, 0,0,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,1,0,8'hA0, 1,1,0,0,0, 1,8'hA0));
    tbl.push_back(mk(1,0,1,0,8'hA1, 2,2,0,0,0, 1,8'hA0));
    // Ten simultaneous wr/rd cycles at count=2: pointers wrap 3->0, order preserved
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1,0,1,1,8'(8'hA2 + k), 2,(3+k)%4,(k+1)%4,0,0, 1,8'(8'hA1 + k)));
    // Fill to full, then wr=rd at full
    tbl.push_back(mk(1,0,1,0,8'hAC, 3,1,2,0,0, 1,8'hAA));
    tbl.push_back(mk(1,0,1,0,8'hAD, 4,2,2,0,0, 1,8'hAA));
    tbl.push_back(mk(1,0,1,1,8'hEE, 3,2,3,1,0, 1,8'hAB));
    tbl.push_back(mk(1,0,0,1,8'h00, 2,2,0,1,0, 1,8'hAC));
    tbl.push_back(mk(1,0,0,1,8'h00, 1,2,1,1,0, 1,8'hAD));
    tbl.push_back(mk(1,0,0,1,8'h00, 0,2,2,1,0, 0,8'h00));
    // wr=rd at empty
    tbl.push_back(mk(1,0,1,1,8'h5A, 1,3,2,1,1, 1,8'h5A));
    // Flush with pending data
    tbl.push_back(mk(1,0,1,0,8'h01, 2,0,2,1,1, 1,8'h5A));
    tbl.push_back(mk(1,0,1,0,8'h02, 3,1,2,1,1, 1,8'h5A));
    tbl.push_back(mk(1,1,1,0,8'hFF, 0,0,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,1,0,8'h77, 1,1,0,0,0, 1,8'h77));
    // Reset mid-operation discards contents
    tbl.push_back(mk(1,0,1,0,8'h88, 2,2,0,0,0, 1,8'h77));
    tbl.push_back(mk(0,0,1,0,8'h99, 0,0,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,0,0,8'h00, 0,0,0,0,0, 0,8'h00));

    bbus.flush = 1'b0; bbus.wr = 1'b0; bbus.rd = 1'b0; bbus.din = '0;

    foreach (tbl[i]) begin
      rst        = tbl[i].r_n;
      sbus.flush = tbl[i].flush;
      sbus.wr    = tbl[i].wr;
      sbus.rd    = tbl[i].rd;
      sbus.din   = tbl[i].din;
      @(posedge clk);
      #1;
      n_vec++;
      chk("count", i, longint'(sbus.count), longint'(tbl[i].count));
      chk("empty", i, longint'(sbus.empty), longint'(tbl[i].count == 0));
      chk("full",  i, longint'(sbus.full),  longint'(tbl[i].count == 4));
      chk("af",    i, longint'(sbus.af),    longint'(tbl[i].count >= 3));
      chk("ae",    i, longint'(sbus.ae),    longint'(tbl[i].count <= 1));
      chk("ovf",   i, longint'(sbus.ovf),   longint'(tbl[i].ovf));
      chk("udf",   i, longint'(sbus.udf),   longint'(tbl[i].udf));
      chk("wa",    i, longint'(sbus.wa),    longint'(tbl[i].wa));
      chk("ra",    i, longint'(sbus.ra),    longint'(tbl[i].ra));
      if (tbl[i].chkd) chk("dout", i, longint'(sbus.dout), longint'(tbl[i].dout));
    end
    sbus.wr = 1'b0; sbus.rd = 1'b0; sbus.flush = 1'b0;

    // Deep instance: 10k cycles of biased random traffic against a queue model
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int  ph, pw, pr;
      bit  w, r, f;
      ph = (cyc / 400) % 3;
      pw = (ph == 1) ? 80 : (ph == 2) ? 25 : 50;
      pr = (ph == 2) ? 80 : (ph == 1) ? 25 : 50;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < pr);
      f  = ($urandom_range(0, 499) == 0);
      bbus.wr    = w;
      bbus.rd    = r;
      bbus.flush = f;
      bbus.din   = 16'($urandom);
      @(posedge clk);
      if (f) begin
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        bit was_full, was_empty;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (w && was_full)  m_ovf = 1'b1;
        if (r && was_empty) m_udf = 1'b1;
        if (r && !was_empty) void'(q.pop_front());
        if (w && !was_full)  q.push_back(bbus.din);
      end
      #1;
      n_vec++;
      chk("rnd_count", cyc, longint'(bbus.count), longint'(q.size()));
      chk("rnd_empty", cyc, longint'(bbus.empty), longint'(q.size() == 0));
      chk("rnd_full",  cyc, longint'(bbus.full),  longint'(q.size() == 16));
      chk("rnd_af",    cyc, longint'(bbus.af),    longint'(q.size() >= 12));
      chk("rnd_ae",    cyc, longint'(bbus.ae),    longint'(q.size() <= 1));
      chk("rnd_ovf",   cyc, longint'(bbus.ovf),   longint'(m_ovf));
      chk("rnd_udf",   cyc, longint'(bbus.udf),   longint'(m_udf));
      if (q.size() != 0) chk("rnd_dout", cyc, longint'(bbus.dout), longint'(q[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
